mem_traffic_gen_chk: RTL and testbench
======================================

// Module: mem_traffic_gen_chk
//
// PURPOSE
//   Synthesizable traffic generator/checker for the memory_controller front-end.
//   Writes NUM_OPS sequential requests, then reads them back in order and checks returned data.
//   Supports selectable data patterns, a base address, an error counter and an idle-timeout watchdog.
//   Sits beside memory_controller and drives its request port, for on-emulator (veloce) self-test.
//
// PARAMETERS
//   DATA_WIDTH    16    request/response data width
//   ADDR_WIDTH    30    request address width
//   NUM_OPS       1023  writes per run; the same number of reads follows (>=1)
//   IDLE_TIMEOUT  200   max clk cycles with reads outstanding and no read_done
//   SEED          16'hA5A5  XOR key for mode 2, zero-extended/truncated to DATA_WIDTH
//
// PORTS
//   clk                 in   1           clock
//   rst                 in   1           synchronous active-high reset
//   start               in   1           pulse; begins a run when in IDLE or DONE
//   mode                in   2           pattern: 0 data=addr, 1 data=~addr, 2 data=addr^SEED, 3 = mode 0; latched at start
//   base_addr           in   ADDR_WIDTH  first address; latched at start
//   out_busy            in   1           controller cannot accept a request this cycle
//   in_valid            out  1           request valid
//   in_request_type     out  1           1 = write, 0 = read
//   in_request_address  out  ADDR_WIDTH  request address
//   in_request_data     out  DATA_WIDTH  write data (0 on reads)
//   read_done           in   1           read data valid, in request order
//   data_out            in   DATA_WIDTH  read data
//   busy                out  1           run in progress
//   done                out  1           run finished (held until next start or rst)
//   pass                out  1           done with err_count==0 and no timeout
//   timeout             out  1           watchdog fired
//   err_count           out  16          mismatches, saturates at 16'hFFFF
//   first_err_addr      out  ADDR_WIDTH  address of the first mismatch
//
// BEHAVIOUR
//   - All outputs registered. On rst: state IDLE, every output 0, counters 0.
//   - Handshake: a request is accepted on a rising clk edge where in_valid=1 and out_busy=0.
//     in_valid, type, address and data stay stable until accepted. The request after an
//     accept is presented the next cycle; peak throughput is one request per cycle.
//   - Address of op k (k = 0..NUM_OPS-1) = base_addr + k, wrapping modulo 2^ADDR_WIDTH.
//     Pattern data uses the low DATA_WIDTH bits of the address (zero-extended if narrower).
//   - FSM:
//       IDLE : start -> WRITE; busy=1, counters cleared, mode and base_addr latched.
//       WRITE: issues writes k=0..NUM_OPS-1. The accept of k=NUM_OPS-1 -> READ, index reset to 0.
//       READ : issues reads k=0..NUM_OPS-1. The accept of the last read -> DRAIN.
//       DRAIN: waits until rd_cnt==NUM_OPS -> DONE.
//       DONE : done=1, busy=0, in_valid=0. pass=(err_count==0)&&!timeout. start -> WRITE.
//     start is ignored in WRITE, READ and DRAIN.
//   - Checking, in READ/DRAIN: on read_done, compare data_out with the pattern for index rd_cnt.
//     On mismatch, increment err_count (saturating). On the first mismatch, capture
//     first_err_addr. Then increment rd_cnt.
//   - read_done when no read is outstanding (rd_cnt == reads accepted) or outside READ/DRAIN:
//     counts as an error; rd_cnt is not advanced.
//   - Watchdog: counts cycles with reads outstanding and no read_done; cleared on any read_done.
//     Reaching IDLE_TIMEOUT -> timeout=1, DONE immediately, in_valid dropped.
//   - read_done coincident with an accept: both are processed in the same cycle.
//   - rst mid-run: abort immediately to IDLE with every output 0; no further requests issued.
//
// TESTING
//   1. NUM_OPS=4, base=0, mode 0, out_busy=0, model echoes each read 3 cycles later ->
//      writes data 0..3 then 4 reads; done=1, pass=1, err_count=0.
//   2. out_busy toggled randomly -> in_valid/addr/data held stable while busy; the sequence of
//      accepted addresses is 0,1,2,3 (writes), then 0,1,2,3 (reads).
//   3. mode 2, SEED=16'hA5A5, base=16'h0010; model corrupts the read of address 16'h0012 ->
//      err_count=1, first_err_addr=16'h0012, pass=0.
//   4. base=2^30-2, NUM_OPS=4 -> addresses 3FFFFFFE, 3FFFFFFF, 0, 1.
//   5. Model drops the last read_done -> timeout=1 exactly IDLE_TIMEOUT cycles after the previous
//      read_done; done=1, pass=0.
//   6. rst asserted during WRITE, then start -> clean run from k=0, with err_count cleared.

Source files
------------

// File: rtl/mem_traffic_gen_chk_if.sv
// rtl/mem_traffic_gen_chk_if.sv - request/response bus between traffic generator and memory controller front-end
//
// Purpose: groups the memory_controller request port and its read-return path.
// Signals:
//   in_valid            request valid (generator -> controller)
//   in_request_type     1 = write, 0 = read
//   in_request_address  request address
//   in_request_data     write data, 0 on reads
//   out_busy            controller cannot accept this cycle (controller -> generator)
//   read_done           read data valid, returned in request order
//   data_out            read data
// Modports: master = traffic generator, slave = memory controller.

interface mem_traffic_gen_chk_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 30
);
  logic                  in_valid;
  logic                  in_request_type;
  logic [ADDR_WIDTH-1:0] in_request_address;
  logic [DATA_WIDTH-1:0] in_request_data;
  logic                  out_busy;
  logic                  read_done;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output in_valid, in_request_type, in_request_address, in_request_data,
    input  out_busy, read_done, data_out
  );

  modport slave (
    input  in_valid, in_request_type, in_request_address, in_request_data,
    output out_busy, read_done, data_out
  );
endinterface

// File: rtl/mem_traffic_gen_chk.sv
// rtl/mem_traffic_gen_chk.sv - write-then-readback traffic generator and data checker
//
// Purpose: on start, writes NUM_OPS patterned words to base_addr+k, reads them back in
// order and compares returned data. Counts mismatches, records the first failing address
// and aborts the run through an idle watchdog when read data stops returning.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse, begins a run from IDLE or DONE
//   mode            data pattern: 0 addr, 1 ~addr, 2 addr^SEED, 3 same as 0
//   base_addr       first address of the run
//   bus             request/response bus (master side)
//   busy, done      run in progress / run finished (held)
//   pass            done with no mismatch and no timeout
//   timeout         watchdog fired
//   err_count       saturating error count
//   first_err_addr  address of the first data mismatch

module mem_traffic_gen_chk #(
  parameter int          DATA_WIDTH   = 16,
  parameter int          ADDR_WIDTH   = 30,
  parameter int          NUM_OPS      = 1023,
  parameter int          IDLE_TIMEOUT = 200,
  parameter logic [15:0] SEED         = 16'hA5A5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  mem_traffic_gen_chk_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int CW = $clog2(NUM_OPS + 1);
  localparam int WW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPS - 1);
  localparam logic [CW-1:0] OPS      = CW'(NUM_OPS);
  localparam logic [WW-1:0] TMO      = WW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         idx;
  logic [CW-1:0]         rd_acc;
  logic [CW-1:0]         rd_cnt;
  logic [WW-1:0]         wd;
  logic                  have_first;

  // The size casts zero-extend or truncate the address and seed to the data width.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [1:0] m);
    logic [DATA_WIDTH-1:0] low;
    logic [DATA_WIDTH-1:0] key;
    low = DATA_WIDTH'(a);
    key = DATA_WIDTH'(SEED);
    case (m)
      2'd1:    return ~low;
      2'd2:    return low ^ key;
      default: return low;
    endcase
  endfunction

  logic                  accept;
  logic                  outstanding;
  logic                  valid_rd;
  logic                  mismatch;
  logic                  err_event;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [15:0]           err_next;
  logic [WW-1:0]         wd_inc;

  always_comb begin
    accept      = bus.in_valid && !bus.out_busy;
    // Registered rd_acc is used on purpose: a read accepted this edge cannot already be returning.
    outstanding = ((state == S_READ) || (state == S_DRAIN)) && (rd_cnt != rd_acc);
    valid_rd    = bus.read_done && outstanding;
    chk_addr    = base_q + ADDR_WIDTH'(rd_cnt);
    next_addr   = bus.in_request_address + ADDR_WIDTH'(1);
    mismatch    = valid_rd && (bus.data_out != pattern(chk_addr, mode_q));
    // Unsolicited read data is an error in its own right.
    err_event   = bus.read_done && (!valid_rd || mismatch);
    err_next    = (err_event && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    wd_inc      = wd + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      mode_q                 <= '0;
      base_q                 <= '0;
      idx                    <= '0;
      rd_acc                 <= '0;
      rd_cnt                 <= '0;
      wd                     <= '0;
      have_first             <= 1'b0;
      bus.in_valid           <= 1'b0;
      bus.in_request_type    <= 1'b0;
      bus.in_request_address <= '0;
      bus.in_request_data    <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      pass                   <= 1'b0;
      timeout                <= 1'b0;
      err_count              <= '0;
      first_err_addr         <= '0;
    end else begin
      // Checker runs every cycle; start below overrides it with a clean slate.
      err_count <= err_next;
      if (valid_rd) rd_cnt <= rd_cnt + CW'(1);
      if (mismatch && !have_first) begin
        have_first     <= 1'b1;
        first_err_addr <= chk_addr;
      end
      if (bus.read_done || !outstanding) wd <= '0;
      else                               wd <= wd_inc;

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) pass <= (err_next == 16'd0) && !timeout;
          if (start) begin
            state                  <= S_WRITE;
            busy                   <= 1'b1;
            done                   <= 1'b0;
            pass                   <= 1'b0;
            timeout                <= 1'b0;
            err_count              <= '0;
            first_err_addr         <= '0;
            have_first             <= 1'b0;
            mode_q                 <= mode;
            base_q                 <= base_addr;
            idx                    <= '0;
            rd_acc                 <= '0;
            rd_cnt                 <= '0;
            wd                     <= '0;
            bus.in_valid           <= 1'b1;
            bus.in_request_type    <= 1'b1;
            bus.in_request_address <= base_addr;
            bus.in_request_data    <= pattern(base_addr, mode);
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              state                  <= S_READ;
              idx                    <= '0;
              bus.in_request_type    <= 1'b0;
              bus.in_request_address <= base_q;
              bus.in_request_data    <= '0;
            end else begin
              idx                    <= idx + CW'(1);
              bus.in_request_address <= next_addr;
              bus.in_request_data    <= pattern(next_addr, mode_q);
            end
          end
        end
        S_READ: begin
          if (accept) begin
            rd_acc <= rd_acc + CW'(1);
            if (idx == LAST_IDX) begin
              state                  <= S_DRAIN;
              bus.in_valid           <= 1'b0;
              bus.in_request_address <= '0;
            end else begin
              idx                    <= idx + CW'(1);
              bus.in_request_address <= next_addr;
            end
          end
        end
        S_DRAIN: begin
          if (rd_cnt == OPS) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog abort wins over any request progress in the same cycle.
      if (outstanding && !bus.read_done && (wd_inc == TMO)) begin
        state        <= S_DONE;
        timeout      <= 1'b1;
        busy         <= 1'b0;
        done         <= 1'b1;
        pass         <= 1'b0;
        bus.in_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_traffic_gen_chk.sv
// tb/tb_mem_traffic_gen_chk.sv - directed self-checking bench for mem_traffic_gen_chk

module tb_mem_traffic_gen_chk;
  localparam int DW   = 16;
  localparam int AW   = 30;
  localparam int NOPS = 4;
  localparam int TMO  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_traffic_gen_chk_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_traffic_gen_chk #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_OPS(NOPS), .IDLE_TIMEOUT(TMO), .SEED(16'hA5A5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct { logic typ; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { logic [DW-1:0] d; int due; } rsp_t;

  req_t          acc_log[$];
  rsp_t          rq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            n_reads      = 0;
  int            drop_idx     = -1;
  logic          corrupt_en   = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  int            inj_req      = 0;
  int            inj_seen     = 0;
  int            last_rd_edge = 0;
  req_t          l_tmp;
  rsp_t          r_tmp;
  logic [DW-1:0] d_tmp;

  // Controller model: logs each request that the next edge accepts, answers reads 3 edges later.
  always @(negedge clk) begin
    bus.read_done = 1'b0;
    bus.data_out  = '0;
    if (rq.size() > 0 && rq[0].due == cyc + 1) begin
      bus.read_done = 1'b1;
      bus.data_out  = rq[0].d;
      void'(rq.pop_front());
      last_rd_edge = cyc + 1;
    end
    if (inj_req != inj_seen) begin
      bus.read_done = 1'b1;
      inj_seen      = inj_req;
    end
    if (!rst && bus.in_valid && !bus.out_busy) begin
      l_tmp.typ  = bus.in_request_type;
      l_tmp.addr = bus.in_request_address;
      l_tmp.data = bus.in_request_data;
      acc_log.push_back(l_tmp);
      if (bus.in_request_type) mem[bus.in_request_address] = bus.in_request_data;
      else begin
        d_tmp = mem.exists(bus.in_request_address) ? mem[bus.in_request_address] : '0;
        if (corrupt_en && bus.in_request_address == corrupt_addr) d_tmp = d_tmp ^ 16'h0100;
        if (n_reads != drop_idx) begin
          r_tmp.d   = d_tmp;
          r_tmp.due = cyc + 4;
          rq.push_back(r_tmp);
        end
        n_reads++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [AW-1:0] b);
    mode      = m;
    base_addr = b;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if ({bus.in_valid, bus.in_request_type} !== 2'b00) begin failures++; $display("FAIL reset_req_ctrl got=%b exp=00", {bus.in_valid, bus.in_request_type}); end
    checks++; if (bus.in_request_address !== '0 || bus.in_request_data !== '0) begin failures++; $display("FAIL reset_req_bus got=%h/%h exp=0/0", bus.in_request_address, bus.in_request_data); end
    checks++; if ({busy, done, pass, timeout} !== 4'b0000) begin failures++; $display("FAIL reset_status got=%b exp=0000", {busy, done, pass, timeout}); end
    checks++; if (err_count !== 16'd0 || first_err_addr !== '0) begin failures++; $display("FAIL reset_err got=%h/%h exp=0/0", err_count, first_err_addr); end
    rst = 1'b0;
    tick(); tick();
    checks++; if ({bus.in_valid, busy} !== 2'b00) begin failures++; $display("FAIL idle_no_start got=%b exp=00", {bus.in_valid, busy}); end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea[8] = '{30'd0, 30'd1, 30'd2, 30'd3, 30'd0, 30'd1, 30'd2, 30'd3};
    logic [DW-1:0] ed[8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
    int lb = acc_log.size();
    bit ok;
    start_run(2'd0, 30'd0);
    checks++; if ({busy, bus.in_valid, bus.in_request_type} !== 3'b111) begin failures++; $display("FAIL basic_first_req got=%b exp=111", {busy, bus.in_valid, bus.in_request_type}); end
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_wait got=%b exp=1", ok); end
    checks++; if ({done, pass, busy, timeout} !== 4'b1100) begin failures++; $display("FAIL basic_status got=%b exp=1100", {done, pass, busy, timeout}); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL basic_err got=%0d exp=0", err_count); end
    checks++; if (acc_log.size() != lb + 8) begin failures++; $display("FAIL basic_log_len got=%0d exp=%0d", acc_log.size() - lb, 8); end
    for (int k = 0; k < 8; k++) if (lb + k < acc_log.size()) begin
      checks++;
      if (acc_log[lb+k].typ !== 1'(k < 4) || acc_log[lb+k].addr !== ea[k] || acc_log[lb+k].data !== ed[k]) begin
        failures++; $display("FAIL basic_req%0d got=%b/%h/%h exp=%b/%h/%h", k, acc_log[lb+k].typ, acc_log[lb+k].addr, acc_log[lb+k].data, 1'(k < 4), ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_busy_stall();
    logic [AW-1:0] ea[8] = '{30'd0, 30'd1, 30'd2, 30'd3, 30'd0, 30'd1, 30'd2, 30'd3};
    int lb = acc_log.size();
    int n = 0;
    logic [AW+DW+1:0] prev, cur;
    logic prev_busy;
    start_run(2'd0, 30'd0);
    bus.out_busy = 1'b1;
    while (!done && n < 400) begin
      prev      = {bus.in_valid, bus.in_request_type, bus.in_request_address, bus.in_request_data};
      prev_busy = bus.out_busy;
      tick();
      n++;
      cur = {bus.in_valid, bus.in_request_type, bus.in_request_address, bus.in_request_data};
      if (prev[AW+DW+1] && prev_busy) begin
        checks++; if (cur !== prev) begin failures++; $display("FAIL stall_hold got=%h exp=%h", cur, prev); end
      end
      start        = (n == 5);
      bus.out_busy = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    bus.out_busy = 1'b0;
    checks++; if ({done, pass} !== 2'b11) begin failures++; $display("FAIL stall_status got=%b exp=11", {done, pass}); end
    checks++; if (acc_log.size() != lb + 8) begin failures++; $display("FAIL stall_log_len got=%0d exp=8", acc_log.size() - lb); end
    for (int k = 0; k < 8; k++) if (lb + k < acc_log.size()) begin
      checks++;
      if (acc_log[lb+k].typ !== 1'(k < 4) || acc_log[lb+k].addr !== ea[k]) begin
        failures++; $display("FAIL stall_req%0d got=%b/%h exp=%b/%h", k, acc_log[lb+k].typ, acc_log[lb+k].addr, 1'(k < 4), ea[k]);
      end
    end
  endtask

  task automatic test_mode2_corrupt();
    logic [DW-1:0] ed[4] = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6};
    int lb = acc_log.size();
    bit ok;
    corrupt_en   = 1'b1;
    corrupt_addr = 30'h12;
    start_run(2'd2, 30'h10);
    wait_done(200, ok);
    corrupt_en = 1'b0;
    checks++; if (!ok || pass !== 1'b0) begin failures++; $display("FAIL m2_status got=%b/%b exp=1/0", ok, pass); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL m2_err got=%0d exp=1", err_count); end
    checks++; if (first_err_addr !== 30'h12) begin failures++; $display("FAIL m2_first got=%h exp=12", first_err_addr); end
    for (int k = 0; k < 4; k++) if (lb + k < acc_log.size()) begin
      checks++;
      if (acc_log[lb+k].addr !== 30'h10 + 30'(k) || acc_log[lb+k].data !== ed[k]) begin
        failures++; $display("FAIL m2_wr%0d got=%h/%h exp=%h/%h", k, acc_log[lb+k].addr, acc_log[lb+k].data, 30'h10 + 30'(k), ed[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea[4] = '{30'h3FFFFFFE, 30'h3FFFFFFF, 30'h0, 30'h1};
    logic [DW-1:0] ed[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    int lb = acc_log.size();
    bit ok;
    start_run(2'd0, 30'h3FFFFFFE);
    wait_done(200, ok);
    checks++; if (!ok || {pass, err_count} !== {1'b1, 16'd0}) begin failures++; $display("FAIL wrap_status got=%b/%b/%0d exp=1/1/0", ok, pass, err_count); end
    for (int k = 0; k < 8; k++) if (lb + k < acc_log.size()) begin
      checks++;
      if (acc_log[lb+k].addr !== ea[k%4] || (k < 4 && acc_log[lb+k].data !== ed[k])) begin
        failures++; $display("FAIL wrap_req%0d got=%h/%h exp=%h/%h", k, acc_log[lb+k].addr, acc_log[lb+k].data, ea[k%4], (k < 4) ? ed[k%4] : 16'h0);
      end
    end
  endtask

  task automatic test_modes_1_3();
    logic [DW-1:0] e1[4] = '{16'hFFFA, 16'hFFF9, 16'hFFF8, 16'hFFF7};
    logic [DW-1:0] e3[4] = '{16'h0007, 16'h0008, 16'h0009, 16'h000A};
    int lb = acc_log.size();
    bit ok;
    start_run(2'd1, 30'd5);
    wait_done(200, ok);
    checks++; if (!ok || pass !== 1'b1) begin failures++; $display("FAIL m1_pass got=%b/%b exp=1/1", ok, pass); end
    for (int k = 0; k < 4; k++) if (lb + k < acc_log.size()) begin
      checks++; if (acc_log[lb+k].data !== e1[k]) begin failures++; $display("FAIL m1_wr%0d got=%h exp=%h", k, acc_log[lb+k].data, e1[k]); end
    end
    lb = acc_log.size();
    start_run(2'd3, 30'd7);
    wait_done(200, ok);
    checks++; if (!ok || pass !== 1'b1) begin failures++; $display("FAIL m3_pass got=%b/%b exp=1/1", ok, pass); end
    for (int k = 0; k < 4; k++) if (lb + k < acc_log.size()) begin
      checks++; if (acc_log[lb+k].data !== e3[k]) begin failures++; $display("FAIL m3_wr%0d got=%h exp=%h", k, acc_log[lb+k].data, e3[k]); end
    end
  endtask

  task automatic test_spurious_done();
    inj_req++;
    tick(); tick();
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL spur_err got=%0d exp=1", err_count); end
    checks++; if ({done, pass} !== 2'b10) begin failures++; $display("FAIL spur_pass got=%b exp=10", {done, pass}); end
  endtask

  task automatic test_reset_midrun();
    int lb;
    bit ok;
    start_run(2'd2, 30'h100);
    inj_req++;
    tick(); tick();
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL mid_err_before got=%0d exp=1", err_count); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.in_valid, busy, done, pass, timeout} !== 5'b0 || err_count !== 16'd0) begin failures++; $display("FAIL mid_rst_out got=%b/%0d exp=00000/0", {bus.in_valid, busy, done, pass, timeout}, err_count); end
    tick();
    rst = 1'b0;
    lb = acc_log.size();
    tick(); tick(); tick();
    checks++; if (acc_log.size() != lb || bus.in_valid !== 1'b0) begin failures++; $display("FAIL mid_quiet got=%0d/%b exp=0/0", acc_log.size() - lb, bus.in_valid); end
    start_run(2'd0, 30'd0);
    wait_done(200, ok);
    checks++; if (!ok || {pass, err_count} !== {1'b1, 16'd0}) begin failures++; $display("FAIL mid_rerun got=%b/%b/%0d exp=1/1/0", ok, pass, err_count); end
    for (int k = 0; k < 8; k++) if (lb + k < acc_log.size()) begin
      checks++;
      if (acc_log[lb+k].typ !== 1'(k < 4) || acc_log[lb+k].addr !== 30'(k % 4)) begin
        failures++; $display("FAIL mid_req%0d got=%b/%h exp=%b/%h", k, acc_log[lb+k].typ, acc_log[lb+k].addr, 1'(k < 4), 30'(k % 4));
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int te;
    drop_idx = n_reads + 3;
    start_run(2'd0, 30'd0);
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    te = cyc;
    drop_idx = -1;
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL tmo_fired got=%b exp=1", timeout); end
    checks++; if (te - last_rd_edge != TMO) begin failures++; $display("FAIL tmo_delay got=%0d exp=%0d", te - last_rd_edge, TMO); end
    checks++; if ({done, pass, busy, bus.in_valid} !== 4'b1000) begin failures++; $display("FAIL tmo_status got=%b exp=1000", {done, pass, busy, bus.in_valid}); end
    tick();
    checks++; if ({done, pass, timeout} !== 3'b101) begin failures++; $display("FAIL tmo_hold got=%b exp=101", {done, pass, timeout}); end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    mode         = 2'd0;
    base_addr    = '0;
    bus.out_busy = 1'b0;
    test_reset();
    test_basic();
    test_busy_stall();
    test_mode2_corrupt();
    test_wrap();
    test_modes_1_3();
    test_spurious_done();
    test_reset_midrun();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1);
  end

endmodule
